// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared constants, coefficients and FSM states for the FIR MAC scheduler
package fir_sched_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OUT_W_DEF  = 20;
  localparam int NTAPS      = 22;
  localparam int NHALF      = 11;

  localparam logic CH_RED = 1'b0;
  localparam logic CH_IR  = 1'b1;

  // Folded half of the symmetric impulse response: h[k] = h[21-k] = COEF[k]
  localparam logic [7:0] COEF [NHALF] = '{
    8'd2, 8'd10, 8'd16, 8'd28, 8'd43, 8'd60, 8'd78, 8'd95, 8'd111, 8'd122, 8'd128
  };

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} fir_state_e;

  function automatic logic [7:0] coef_at(input logic [3:0] k);
    if (k < 4'(NHALF)) return COEF[k];
    return 8'd0;
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// rtl/fir_mac_scheduler_if.sv - sample handshakes and tagged result bus of the FIR MAC scheduler
interface fir_mac_scheduler_if
  import fir_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
);

  logic              red_valid;
  logic [DATA_W-1:0] red_sample;
  logic              red_ready;
  logic              ir_valid;
  logic [DATA_W-1:0] ir_sample;
  logic              ir_ready;
  logic              out_valid;
  logic              out_ch;
  logic [OUT_W-1:0]  out_data;

  modport master (
    output red_valid, red_sample, ir_valid, ir_sample,
    input  red_ready, ir_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  red_valid, red_sample, ir_valid, ir_sample,
    output red_ready, ir_ready, out_valid, out_ch, out_data
  );

endinterface

// File: rtl/fir_hist_line.sv
// rtl/fir_hist_line.sv - 22-entry sample history with clear, shift and paired k / 21-k read ports
module fir_hist_line
  import fir_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK_Filter,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [3:0]        k_i,
  output logic [DATA_W-1:0] tap_k_o,
  output logic [DATA_W-1:0] tap_mirror_o
);

  logic [DATA_W-1:0] hist_q [NTAPS];
  logic [4:0]        idx_k;
  logic [4:0]        idx_m;

  assign idx_k        = {1'b0, k_i};
  assign idx_m        = 5'(NTAPS - 1) - idx_k;
  assign tap_k_o      = hist_q[idx_k];
  assign tap_mirror_o = hist_q[idx_m];

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) hist_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < NTAPS; i++) hist_q[i] <= '0;
    end else if (shift_i) begin
      hist_q[0] <= din_i;
      for (int i = 1; i < NTAPS; i++) hist_q[i] <= hist_q[i-1];
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - shared folded 22-tap FIR MAC for RED/IR channels, round-robin scheduled
// Optional IR channel: define FIR_SCHED_IR_EN; otherwise only RED is built and always granted.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic               CLK_Filter,
  input  logic               rst_n,
  input  logic               flush,
  fir_mac_scheduler_if.slave bus,
  output logic               busy
);

  localparam int PROD_W = DATA_W + 9;

  fir_state_e        state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic              grant_q, grant_d;
  logic              next_grant;
  logic              load;

  logic              red_pend_q, red_pend_d;
  logic [DATA_W-1:0] red_data_q;
  logic              red_accept;
  logic              red_take;
  logic              ir_pend_q;

  logic [DATA_W-1:0] red_tap_k, red_tap_m;
  logic [DATA_W-1:0] ir_tap_k, ir_tap_m;
  logic [DATA_W-1:0] tap_k, tap_m;
  logic [DATA_W:0]   pre_sum;
  logic [PROD_W-1:0] product;

  logic              out_valid_q;
  logic              out_ch_q;
  logic [OUT_W-1:0]  out_data_q;

  // A pending slot clears on the LOAD edge, i.e. when its channel enters MAC
  assign red_take       = load && (grant_q == CH_RED);
  assign bus.red_ready  = !red_pend_q && !flush;
  assign red_accept     = bus.red_valid && bus.red_ready;
  assign red_pend_d     = red_accept || (red_pend_q && !red_take);

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      red_pend_q <= 1'b0;
      red_data_q <= '0;
    end else if (flush) begin
      red_pend_q <= 1'b0;
    end else begin
      red_pend_q <= red_pend_d;
      if (red_accept) red_data_q <= bus.red_sample;
    end
  end

  fir_hist_line #(.DATA_W(DATA_W)) u_red_hist (
    .CLK_Filter   (CLK_Filter),
    .rst_n        (rst_n),
    .clr_i        (flush),
    .shift_i      (red_take),
    .din_i        (red_data_q),
    .k_i          (k_q),
    .tap_k_o      (red_tap_k),
    .tap_mirror_o (red_tap_m)
  );

`ifdef FIR_SCHED_IR_EN
  logic              ir_pend_d;
  logic [DATA_W-1:0] ir_data_q;
  logic              ir_accept;
  logic              ir_take;

  assign ir_take       = load && (grant_q == CH_IR);
  assign bus.ir_ready  = !ir_pend_q && !flush;
  assign ir_accept     = bus.ir_valid && bus.ir_ready;
  assign ir_pend_d     = ir_accept || (ir_pend_q && !ir_take);

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      ir_pend_q <= 1'b0;
      ir_data_q <= '0;
    end else if (flush) begin
      ir_pend_q <= 1'b0;
    end else begin
      ir_pend_q <= ir_pend_d;
      if (ir_accept) ir_data_q <= bus.ir_sample;
    end
  end

  fir_hist_line #(.DATA_W(DATA_W)) u_ir_hist (
    .CLK_Filter   (CLK_Filter),
    .rst_n        (rst_n),
    .clr_i        (flush),
    .shift_i      (ir_take),
    .din_i        (ir_data_q),
    .k_i          (k_q),
    .tap_k_o      (ir_tap_k),
    .tap_mirror_o (ir_tap_m)
  );

  // Round-robin: on a tie the channel not served last wins; a lone requester always wins
  always_comb begin
    next_grant = CH_IR;
    if (red_pend_q && ir_pend_q) next_grant = (grant_q == CH_IR) ? CH_RED : CH_IR;
    else if (red_pend_q)         next_grant = CH_RED;
  end
`else
  logic unused_ir;

  assign unused_ir    = bus.ir_valid ^ (^bus.ir_sample);
  assign bus.ir_ready = 1'b0;
  assign ir_pend_q    = 1'b0;
  assign ir_tap_k     = '0;
  assign ir_tap_m     = '0;
  assign next_grant   = CH_RED;
`endif

  assign tap_k   = (grant_q == CH_IR) ? ir_tap_k : red_tap_k;
  assign tap_m   = (grant_q == CH_IR) ? ir_tap_m : red_tap_m;
  assign pre_sum = {1'b0, tap_k} + {1'b0, tap_m};
  assign product = PROD_W'(coef_at(k_q)) * PROD_W'(pre_sum);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    grant_d = grant_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (red_pend_q || ir_pend_q) begin
          grant_d = next_grant;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        acc_d   = '0;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + OUT_W'(product);
        k_d   = k_q + 4'd1;
        if (k_q == 4'(NHALF - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      k_d     = '0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      grant_q <= CH_IR;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= CH_RED;
      out_data_q  <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == DONE);
      if (state_q == DONE) begin
        out_data_q <= acc_q;
        out_ch_q   <= grant_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != IDLE);

endmodule
